// File: rtl/multicycle_alu_pkg.sv
// Shared opcodes, flag bit positions and FSM state type for multicycle_alu.
package multicycle_alu_pkg;

   localparam logic [4:0] OP_A    = 5'd0;
   localparam logic [4:0] OP_B    = 5'd1;
   localparam logic [4:0] OP_NOTA = 5'd2;
   localparam logic [4:0] OP_NOTB = 5'd3;
   localparam logic [4:0] OP_ADD  = 5'd4;
   localparam logic [4:0] OP_ADC  = 5'd5;
   localparam logic [4:0] OP_SUB  = 5'd6;
   localparam logic [4:0] OP_AND  = 5'd7;
   localparam logic [4:0] OP_OR   = 5'd8;
   localparam logic [4:0] OP_XOR  = 5'd9;
   localparam logic [4:0] OP_NAND = 5'd10;
   localparam logic [4:0] OP_LSL  = 5'd11;
   localparam logic [4:0] OP_LSR  = 5'd12;
   localparam logic [4:0] OP_ASR  = 5'd13;
   localparam logic [4:0] OP_CSL  = 5'd14;
   localparam logic [4:0] OP_CSR  = 5'd15;
   localparam logic [4:0] OP_MUL  = 5'd16;
   localparam logic [4:0] OP_DIV  = 5'd17;
   localparam logic [4:0] OP_MOD  = 5'd18;

   localparam int unsigned FLAG_Z = 3;
   localparam int unsigned FLAG_C = 2;
   localparam int unsigned FLAG_N = 1;
   localparam int unsigned FLAG_O = 0;

   typedef enum logic {IDLE, ITER} state_t;

endpackage

// File: rtl/multicycle_alu_iter.sv
// Iterative shift-add multiplier and restoring divider, one bit per step.
// The divider datapath exists only when MULTICYCLE_ALU_DIV_EN is defined.
module multicycle_alu_iter
   import multicycle_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic               Clock,
   input  logic               Reset,
   input  logic               start,
   input  logic               run,
   input  logic [4:0]         op,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   output logic               last_step,
   output logic [2*WIDTH-1:0] product,
   output logic [WIDTH-1:0]   quotient,
   output logic [WIDTH-1:0]   remainder
);

   localparam int unsigned CW = $clog2(WIDTH);

   logic [CW-1:0]      step;
   logic [2*WIDTH-1:0] acc;
   logic [2*WIDTH-1:0] mcand;
   logic [WIDTH-1:0]   mplier;

   assign last_step = run && (step == CW'(WIDTH - 1));

   // Results are the next-step values so the final step can be registered directly.
   assign product = mplier[0] ? acc + mcand : acc;

   always_ff @(posedge Clock) begin
      if (Reset) begin
         step   <= '0;
         acc    <= '0;
         mcand  <= '0;
         mplier <= '0;
      end else if (start) begin
         step <= '0;
         if (op == OP_MUL) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, a};
            mplier <= b;
         end
      end else if (run) begin
         step   <= last_step ? '0 : step + CW'(1);
         acc    <= product;
         mcand  <= mcand << 1;
         mplier <= mplier >> 1;
      end
   end

`ifdef MULTICYCLE_ALU_DIV_EN
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] dvsr;
   logic [WIDTH:0]   trial;
   logic [WIDTH:0]   diff;

   always_comb begin
      trial = {rem, quo[WIDTH-1]};
      diff  = trial - {1'b0, dvsr};
      if (diff[WIDTH]) begin
         quotient  = {quo[WIDTH-2:0], 1'b0};
         remainder = trial[WIDTH-1:0];
      end else begin
         quotient  = {quo[WIDTH-2:0], 1'b1};
         remainder = diff[WIDTH-1:0];
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         quo  <= '0;
         rem  <= '0;
         dvsr <= '0;
      end else if (start) begin
         if (op != OP_MUL) begin
            quo  <= a;
            rem  <= '0;
            dvsr <= b;
         end
      end else if (run) begin
         quo <= quotient;
         rem <= remainder;
      end
   end
`else
   assign quotient  = '0;
   assign remainder = '0;
`endif

endmodule

// File: rtl/multicycle_alu.sv
// Parametrised ALU: registered single-cycle ops plus iterative MUL/DIV/MOD with
// a Start/Busy/Done handshake. DIV/MOD are built only with MULTICYCLE_ALU_DIV_EN.
module multicycle_alu
   import multicycle_alu_pkg::*;
#(
   parameter int unsigned WIDTH = 16
) (
   input  logic             Clock,
   input  logic             Reset,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic [4:0]       FunSel,
   input  logic             WF,
   input  logic             Start,
   output logic [WIDTH-1:0] ALUOut,
   output logic [3:0]       FlagsOut,
   output logic             Busy,
   output logic             Done
);

   localparam int unsigned MSB = WIDTH - 1;

   state_t             state;
   logic [4:0]         op_q;
   logic               wf_q;

   logic [WIDTH:0]     sum;
   logic [WIDTH-1:0]   sc_res;
   logic [3:0]         sc_flags;
   logic [WIDTH-1:0]   it_res;
   logic [3:0]         it_flags;
   logic [WIDTH-1:0]   dz_res;
   logic [3:0]         dz_flags;

   logic               is_single;
   logic               is_mul;
   logic               is_div;
   logic               div_zero;
   logic               iter_start;
   logic               last_step;
   logic [2*WIDTH-1:0] product;
   logic [WIDTH-1:0]   quotient;
   logic [WIDTH-1:0]   remainder;

   assign is_single = !FunSel[4];
   assign is_mul    = (FunSel == OP_MUL);
`ifdef MULTICYCLE_ALU_DIV_EN
   assign is_div    = (FunSel == OP_DIV) || (FunSel == OP_MOD);
`else
   assign is_div    = 1'b0;
`endif
   assign div_zero   = is_div && (B == '0);
   assign iter_start = Start && (state == IDLE) && (is_mul || (is_div && !div_zero));

   // Unaffected flags default to the current register so WF can write all four.
   always_comb begin
      sum      = '0;
      sc_res   = '0;
      sc_flags = FlagsOut;
      case (FunSel)
         OP_A:    sc_res = A;
         OP_B:    sc_res = B;
         OP_NOTA: sc_res = ~A;
         OP_NOTB: sc_res = ~B;
         OP_ADD, OP_ADC: begin
            sum = {1'b0, A} + {1'b0, B}
                + {{WIDTH{1'b0}}, (FunSel == OP_ADC) & FlagsOut[FLAG_C]};
            sc_res           = sum[MSB:0];
            sc_flags[FLAG_C] = sum[WIDTH];
            sc_flags[FLAG_O] = (A[MSB] == B[MSB]) && (sc_res[MSB] != A[MSB]);
         end
         OP_SUB: begin
            sum              = {1'b0, A} + {1'b0, ~B} + (WIDTH+1)'(1);
            sc_res           = sum[MSB:0];
            sc_flags[FLAG_C] = ~sum[WIDTH];
            sc_flags[FLAG_O] = (A[MSB] != B[MSB]) && (sc_res[MSB] != A[MSB]);
         end
         OP_AND:  sc_res = A & B;
         OP_OR:   sc_res = A | B;
         OP_XOR:  sc_res = A ^ B;
         OP_NAND: sc_res = ~(A & B);
         OP_LSL: begin
            sc_res           = {A[MSB-1:0], 1'b0};
            sc_flags[FLAG_C] = A[MSB];
         end
         OP_LSR: begin
            sc_res           = {1'b0, A[MSB:1]};
            sc_flags[FLAG_C] = A[0];
         end
         OP_ASR: begin
            sc_res           = {A[MSB], A[MSB:1]};
            sc_flags[FLAG_C] = A[0];
         end
         OP_CSL: begin
            sc_res           = {A[MSB-1:0], A[MSB]};
            sc_flags[FLAG_C] = A[MSB];
         end
         OP_CSR: begin
            sc_res           = {A[0], A[MSB:1]};
            sc_flags[FLAG_C] = A[0];
         end
         default: ;
      endcase
      sc_flags[FLAG_Z] = (sc_res == '0);
      sc_flags[FLAG_N] = sc_res[MSB];
   end

   always_comb begin
      if (op_q == OP_MUL)      it_res = product[MSB:0];
      else if (op_q == OP_DIV) it_res = quotient;
      else                     it_res = remainder;
      it_flags         = '0;
      it_flags[FLAG_Z] = (it_res == '0);
      it_flags[FLAG_N] = it_res[MSB];
      it_flags[FLAG_C] = (op_q == OP_MUL) && (product[2*WIDTH-1:WIDTH] != '0);
   end

   always_comb begin
      dz_res           = (FunSel == OP_DIV) ? '1 : A;
      dz_flags         = '0;
      dz_flags[FLAG_Z] = (dz_res == '0);
      dz_flags[FLAG_N] = dz_res[MSB];
      dz_flags[FLAG_O] = 1'b1;
   end

   multicycle_alu_iter #(.WIDTH(WIDTH)) u_iter (
      .Clock     (Clock),
      .Reset     (Reset),
      .start     (iter_start),
      .run       (state == ITER),
      .op        (FunSel),
      .a         (A),
      .b         (B),
      .last_step (last_step),
      .product   (product),
      .quotient  (quotient),
      .remainder (remainder)
   );

   always_ff @(posedge Clock) begin
      if (Reset) begin
         state    <= IDLE;
         op_q     <= '0;
         wf_q     <= 1'b0;
         ALUOut   <= '0;
         FlagsOut <= '0;
         Busy     <= 1'b0;
         Done     <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               if (iter_start) begin
                  state <= ITER;
                  Busy  <= 1'b1;
                  op_q  <= FunSel;
                  wf_q  <= WF;
               end else if (Start) begin
                  Done <= 1'b1;
                  if (is_single) begin
                     ALUOut <= sc_res;
                     if (WF) FlagsOut <= sc_flags;
                  end else if (div_zero) begin
                     ALUOut <= dz_res;
                     if (WF) FlagsOut <= dz_flags;
                  end else begin
                     ALUOut <= '0;
                  end
               end
            end
            ITER: begin
               if (last_step) begin
                  state  <= IDLE;
                  Busy   <= 1'b0;
                  Done   <= 1'b1;
                  ALUOut <= it_res;
                  if (wf_q) FlagsOut <= it_flags;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu at WIDTH=16 and WIDTH=8; expectations
// follow MULTICYCLE_ALU_DIV_EN when it is defined.
module tb_multicycle_alu;
   import multicycle_alu_pkg::*;

   typedef struct {
      logic [15:0] out;
      logic [3:0]  flags;
      int          cyc;
   } exp_t;

   logic        Clock;
   logic        rst16, rst8;
   logic [15:0] a16, b16, out16;
   logic [7:0]  a8, b8, out8;
   logic [4:0]  fs16, fs8;
   logic        wf16, wf8, st16, st8;
   logic [3:0]  fl16, fl8;
   logic        busy16, busy8, done16, done8;

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   exp_t q16[$];
   exp_t q8[$];
   exp_t e16, e8;
   logic [3:0] flags_before;

   multicycle_alu #(.WIDTH(16)) u16 (
      .Clock(Clock), .Reset(rst16), .A(a16), .B(b16), .FunSel(fs16), .WF(wf16),
      .Start(st16), .ALUOut(out16), .FlagsOut(fl16), .Busy(busy16), .Done(done16)
   );

   multicycle_alu #(.WIDTH(8)) u8 (
      .Clock(Clock), .Reset(rst8), .A(a8), .B(b8), .FunSel(fs8), .WF(wf8),
      .Start(st8), .ALUOut(out8), .FlagsOut(fl8), .Busy(busy8), .Done(done8)
   );

   initial begin
      Clock = 1'b0;
      forever #5 Clock = ~Clock;
   end

   always @(posedge Clock) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   always @(negedge Clock) begin
      if (done16) begin
         if (q16.size() == 0) begin
            check("unexpected_done16", 32'd1, 32'd0);
         end else begin
            e16 = q16.pop_front();
            check("out16", {16'd0, out16}, {16'd0, e16.out});
            check("flags16", {28'd0, fl16}, {28'd0, e16.flags});
            check("lat16", cyc, e16.cyc);
         end
      end
   end

   always @(negedge Clock) begin
      if (done8) begin
         if (q8.size() == 0) begin
            check("unexpected_done8", 32'd1, 32'd0);
         end else begin
            e8 = q8.pop_front();
            check("out8", {24'd0, out8}, {24'd0, e8.out[7:0]});
            check("flags8", {28'd0, fl8}, {28'd0, e8.flags});
            check("lat8", cyc, e8.cyc);
         end
      end
   end

   // Drives one request; d is the extra edges beyond the accepting edge before Done.
   task automatic issue16(input logic [4:0] fs, input logic [15:0] a, input logic [15:0] b,
                          input logic wf, input logic push, input logic [15:0] eo,
                          input logic [3:0] ef, input int d);
      exp_t x;
      fs16 = fs; a16 = a; b16 = b; wf16 = wf; st16 = 1'b1;
      x.out = eo; x.flags = ef; x.cyc = cyc + 1 + d;
      if (push) q16.push_back(x);
      @(negedge Clock);
      st16 = 1'b0;
   endtask

   task automatic issue8(input logic [4:0] fs, input logic [7:0] a, input logic [7:0] b,
                         input logic wf, input logic [7:0] eo, input logic [3:0] ef,
                         input int d);
      exp_t x;
      fs8 = fs; a8 = a; b8 = b; wf8 = wf; st8 = 1'b1;
      x.out = {8'd0, eo}; x.flags = ef; x.cyc = cyc + 1 + d;
      q8.push_back(x);
      @(negedge Clock);
      st8 = 1'b0;
   endtask

   task automatic drain16();
      for (int i = 0; i < 100; i++) begin
         @(negedge Clock); #1;
         if (q16.size() == 0) return;
      end
      check("drain16_timeout", 32'd1, 32'd0);
   endtask

   task automatic drain8();
      for (int i = 0; i < 100; i++) begin
         @(negedge Clock); #1;
         if (q8.size() == 0) return;
      end
      check("drain8_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      rst16 = 1'b1; rst8 = 1'b1;
      st16 = 1'b0; st8 = 1'b0;
      a16 = '0; b16 = '0; fs16 = '0; wf16 = 1'b0;
      a8 = '0; b8 = '0; fs8 = '0; wf8 = 1'b0;
      repeat (3) @(negedge Clock);
      check("rst_out16", {16'd0, out16}, 32'd0);
      check("rst_flags16", {28'd0, fl16}, 32'd0);
      check("rst_busy16", {31'd0, busy16}, 32'd0);
      check("rst_done16", {31'd0, done16}, 32'd0);
      check("rst_out8", {24'd0, out8}, 32'd0);
      rst16 = 1'b0; rst8 = 1'b0;
      @(negedge Clock);

      // Back-to-back single-cycle ops
      issue16(OP_ADD,  16'h7FFF, 16'h0001, 1'b1, 1'b1, 16'h8000, 4'b0011, 0);
      issue16(OP_SUB,  16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 4'b0110, 0);
      issue16(OP_ADC,  16'h0001, 16'h0001, 1'b1, 1'b1, 16'h0003, 4'b0000, 0);
      issue16(OP_LSL,  16'h8001, 16'h0000, 1'b1, 1'b1, 16'h0002, 4'b0100, 0);
      issue16(OP_ASR,  16'h8002, 16'h0000, 1'b1, 1'b1, 16'hC001, 4'b0010, 0);
      issue16(OP_XOR,  16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'h0000, 4'b1000, 0);
      issue16(OP_NAND, 16'hFFFF, 16'h0F0F, 1'b1, 1'b1, 16'hF0F0, 4'b0010, 0);
      drain16();

      // MUL with an ignored Start while busy, then a second MUL issued in the Done cycle
      issue16(OP_MUL, 16'h0100, 16'h0100, 1'b1, 1'b1, 16'h0000, 4'b1100, 16);
      check("busy_mul_start", {31'd0, busy16}, 32'd1);
      repeat (3) @(negedge Clock);
      fs16 = OP_ADD; a16 = 16'h0001; b16 = 16'h0001; wf16 = 1'b1; st16 = 1'b1;
      @(negedge Clock);
      st16 = 1'b0;
      check("busy_mul_mid", {31'd0, busy16}, 32'd1);
      drain16();
      issue16(OP_MUL, 16'h0012, 16'h0034, 1'b1, 1'b1, 16'h03A8, 4'b0000, 16);
      drain16();

      issue16(OP_SUB, 16'h0001, 16'h0002, 1'b1, 1'b1, 16'hFFFF, 4'b0110, 0);
`ifdef MULTICYCLE_ALU_DIV_EN
      issue16(OP_DIV, 16'd100, 16'd7, 1'b1, 1'b1, 16'h000E, 4'b0000, 16);
      drain16();
      issue16(OP_MOD, 16'd100, 16'd7, 1'b1, 1'b1, 16'h0002, 4'b0000, 16);
      drain16();
      issue16(OP_DIV, 16'd5, 16'd0, 1'b1, 1'b1, 16'hFFFF, 4'b0011, 0);
      issue16(OP_MOD, 16'd9, 16'd0, 1'b1, 1'b1, 16'h0009, 4'b0001, 0);
      flags_before = 4'b0001;
`else
      issue16(OP_DIV, 16'd100, 16'd7, 1'b1, 1'b1, 16'h0000, 4'b0110, 0);
      issue16(OP_MOD, 16'd100, 16'd7, 1'b1, 1'b1, 16'h0000, 4'b0110, 0);
      issue16(OP_DIV, 16'd5, 16'd0, 1'b1, 1'b1, 16'h0000, 4'b0110, 0);
      flags_before = 4'b0110;
`endif
      issue16(5'd25, 16'h1234, 16'h5678, 1'b1, 1'b1, 16'h0000, flags_before, 0);
      issue16(OP_ADD, 16'h0001, 16'h0001, 1'b0, 1'b1, 16'h0002, flags_before, 0);
      drain16();

      // Reset during the 5th ITER cycle of a MUL aborts it with no Done
      issue16(OP_MUL, 16'h0003, 16'h0003, 1'b1, 1'b0, 16'h0000, 4'b0000, 16);
      check("busy_before_abort", {31'd0, busy16}, 32'd1);
      repeat (4) @(negedge Clock);
      rst16 = 1'b1;
      @(negedge Clock);
      check("abort_out16", {16'd0, out16}, 32'd0);
      check("abort_flags16", {28'd0, fl16}, 32'd0);
      check("abort_busy16", {31'd0, busy16}, 32'd0);
      check("abort_done16", {31'd0, done16}, 32'd0);
      rst16 = 1'b0;
      repeat (20) @(negedge Clock);
      issue16(OP_ADD, 16'h0002, 16'h0003, 1'b1, 1'b1, 16'h0005, 4'b0000, 0);
      drain16();

      // WIDTH=8 rotates and multiply
      issue8(OP_ADD, 8'h7F, 8'h01, 1'b1, 8'h80, 4'b0011, 0);
      issue8(OP_CSL, 8'h81, 8'h00, 1'b0, 8'h03, 4'b0011, 0);
      issue8(OP_CSR, 8'h01, 8'h00, 1'b1, 8'h80, 4'b0111, 0);
      drain8();
      issue8(OP_MUL, 8'h10, 8'h20, 1'b1, 8'h00, 4'b1100, 8);
      drain8();

      repeat (3) @(negedge Clock);
      check("q16_empty", q16.size(), 32'd0);
      check("q8_empty", q8.size(), 32'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
